// File: rtl/qa_drv_prim_hazard_sched_if.sv
// Request/response bundle for the hazard scheduler: read and write request streams,
// the shared memory request channel, write completions and status.
interface qa_drv_prim_hazard_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WR_OUT = 32
);
    localparam int CNT_W = $clog2(MAX_WR_OUT + 1);

    logic                  rd_req_valid;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_req_ready;
    logic                  wr_req_valid;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic                  wr_req_ready;
    logic                  mem_req_valid;
    logic                  mem_req_is_wr;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  wr_done_valid;
    logic [ADDR_WIDTH-1:0] wr_done_addr;
    logic [CNT_W-1:0]      wr_out_cnt;
    logic                  err_underflow;

    // master: the requesters / memory model side
    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready,
        output wr_req_valid, wr_req_addr,
        input  wr_req_ready,
        input  mem_req_valid, mem_req_is_wr, mem_req_addr,
        output mem_req_ready,
        output wr_done_valid, wr_done_addr,
        input  wr_out_cnt, err_underflow
    );

    // slave: the scheduler itself
    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready,
        input  wr_req_valid, wr_req_addr,
        output wr_req_ready,
        output mem_req_valid, mem_req_is_wr, mem_req_addr,
        input  mem_req_ready,
        input  wr_done_valid, wr_done_addr,
        output wr_out_cnt, err_underflow
    );
endinterface

// File: rtl/qa_drv_prim_hazard_sched.sv
// Read/write arbiter onto one memory request channel with read-after-write hazard
// tracking through hashed per-bucket counters of in-flight writes.
module qa_drv_prim_hazard_sched #(
    parameter int ADDR_WIDTH      = 32,
    parameter int N_BUCKETS       = 16,
    parameter int BITS_PER_BUCKET = 4,
    parameter int MAX_WR_OUT      = 32
) (
    input  logic                        clk,
    input  logic                        resetb,
    qa_drv_prim_hazard_sched_if.slave   bus
);
    localparam int IDX_W = $clog2(N_BUCKETS);
    localparam int CNT_W = $clog2(MAX_WR_OUT + 1);
    localparam int BKT_W = BITS_PER_BUCKET;

    typedef enum logic {
        RR_READ  = 1'b0,
        RR_WRITE = 1'b1
    } rr_t;

    rr_t                          rr_last_reg;
    rr_t                          rr_last_next;
    logic [N_BUCKETS-1:0][BKT_W-1:0] cnt_all;
    logic [CNT_W-1:0]             wr_out_reg;
    logic                         err_reg;
    logic                         mem_valid_reg;
    logic                         mem_is_wr_reg;
    logic [ADDR_WIDTH-1:0]        mem_addr_reg;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] done_idx;
    logic             slot_free;
    logic             rd_elig;
    logic             wr_elig;
    logic             gnt_rd;
    logic             gnt_wr;
    logic             done_bkt_zero;
    logic             done_out_zero;
    logic             underflow_hit;

    // Fold the two low index-wide slices of the address together.
    function automatic logic [IDX_W-1:0] hash_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0] ^ a[2*IDX_W-1:IDX_W];
    endfunction

    assign rd_idx   = hash_idx(bus.rd_req_addr);
    assign wr_idx   = hash_idx(bus.wr_req_addr);
    assign done_idx = hash_idx(bus.wr_done_addr);

    assign slot_free = !mem_valid_reg || bus.mem_req_ready;
    assign rd_elig   = bus.rd_req_valid && (cnt_all[rd_idx] == '0);
    // A bucket stops taking writes once its top bit is set, so it can never wrap.
    assign wr_elig   = bus.wr_req_valid && !cnt_all[wr_idx][BKT_W-1]
                       && (wr_out_reg < CNT_W'(MAX_WR_OUT));

    always_comb begin
        gnt_rd       = 1'b0;
        gnt_wr       = 1'b0;
        rr_last_next = rr_last_reg;
        if (resetb && slot_free) begin
            if (rd_elig && wr_elig) begin
                if (rr_last_reg == RR_WRITE) gnt_rd = 1'b1;
                else                         gnt_wr = 1'b1;
            end else begin
                gnt_rd = rd_elig;
                gnt_wr = wr_elig;
            end
        end
        if (gnt_rd) rr_last_next = RR_READ;
        if (gnt_wr) rr_last_next = RR_WRITE;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) rr_last_reg <= RR_WRITE;
        else         rr_last_reg <= rr_last_next;
    end

    assign done_bkt_zero = (cnt_all[done_idx] == '0);
    assign done_out_zero = (wr_out_reg == '0);
    assign underflow_hit = bus.wr_done_valid && (done_bkt_zero || done_out_zero);

    // Per-bucket in-flight counters; a completion never decrements a zero bucket.
    for (genvar gi = 0; gi < N_BUCKETS; gi++) begin : g_bucket
        logic [BKT_W-1:0] cnt_reg;
        logic             inc;
        logic             dec;

        assign inc = gnt_wr && (wr_idx == IDX_W'(gi));
        assign dec = bus.wr_done_valid && (done_idx == IDX_W'(gi)) && (cnt_reg != '0);

        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                cnt_reg <= '0;
            end else if (inc && !dec) begin
                cnt_reg <= cnt_reg + BKT_W'(1);
            end else if (dec && !inc) begin
                cnt_reg <= cnt_reg - BKT_W'(1);
            end
        end

        assign cnt_all[gi] = cnt_reg;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_out_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (gnt_wr && !(bus.wr_done_valid && !done_out_zero)) begin
                wr_out_reg <= wr_out_reg + CNT_W'(1);
            end else if (!gnt_wr && bus.wr_done_valid && !done_out_zero) begin
                wr_out_reg <= wr_out_reg - CNT_W'(1);
            end
            if (underflow_hit) err_reg <= 1'b1;
        end
    end

    // Held request: loads on grant, holds under backpressure, drops once taken.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mem_valid_reg <= 1'b0;
            mem_is_wr_reg <= 1'b0;
            mem_addr_reg  <= '0;
        end else if (gnt_rd || gnt_wr) begin
            mem_valid_reg <= 1'b1;
            mem_is_wr_reg <= gnt_wr;
            mem_addr_reg  <= gnt_wr ? bus.wr_req_addr : bus.rd_req_addr;
        end else if (bus.mem_req_ready) begin
            mem_valid_reg <= 1'b0;
        end
    end

    assign bus.rd_req_ready  = gnt_rd;
    assign bus.wr_req_ready  = gnt_wr;
    assign bus.mem_req_valid = mem_valid_reg;
    assign bus.mem_req_is_wr = mem_is_wr_reg;
    assign bus.mem_req_addr  = mem_addr_reg;
    assign bus.wr_out_cnt    = wr_out_reg;
    assign bus.err_underflow = err_reg;
endmodule

// File: tb/tb_qa_drv_prim_hazard_sched.sv
// Scoreboard bench: a queue-based reference model predicts grants and the memory
// request sequence; a negedge monitor checks what the scheduler presents.
module tb_qa_drv_prim_hazard_sched;
    localparam int AW   = 32;
    localparam int NB   = 16;
    localparam int BPB  = 4;
    localparam int MAXW = 32;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    qa_drv_prim_hazard_sched_if #(.ADDR_WIDTH(AW), .MAX_WR_OUT(MAXW)) bus ();

    qa_drv_prim_hazard_sched #(
        .ADDR_WIDTH(AW), .N_BUCKETS(NB), .BITS_PER_BUCKET(BPB), .MAX_WR_OUT(MAXW)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mcnt [NB];
    int          mwr;
    bit          mvalid;
    bit          mrr_wr;
    bit          merr;
    logic [32:0] sb [$];
    logic [31:0] outstanding [$];
    bit          p_gr, p_gw, p_dv, p_mr;
    logic [31:0] p_wa, p_da;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int h(input logic [31:0] a);
        return int'(a % 16) ^ int'((a / 16) % 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) mcnt[i] = 0;
        mwr = 0; mvalid = 0; mrr_wr = 1; merr = 0;
        sb.delete(); outstanding.delete();
        p_gr = 0; p_gw = 0; p_dv = 0; p_mr = 0; p_wa = '0; p_da = '0;
    endtask

    // Effects of the cycle that just ended; completion is judged on pre-edge counts.
    task automatic apply_model();
        int b;
        if (p_dv) begin
            b = h(p_da);
            if (mcnt[b] == 0 || mwr == 0) merr = 1;
            if (mcnt[b] > 0) mcnt[b]--;
            if (mwr > 0) mwr--;
        end
        if (p_gw) begin
            mcnt[h(p_wa)]++;
            mwr++;
            outstanding.push_back(p_wa);
        end
        if (p_gr || p_gw) mvalid = 1;
        else if (p_mr)    mvalid = 0;
        if (p_gr) mrr_wr = 0;
        if (p_gw) mrr_wr = 1;
    endtask

    task automatic step(input bit rv, input logic [31:0] ra, input bit wv, input logic [31:0] wa,
                        input bit mr, input bit dv, input logic [31:0] da);
        bit slot, re, we, gr, gw;
        @(posedge clk); #1;
        apply_model();
        chk("wr_out_cnt", 64'(bus.wr_out_cnt), 64'(mwr));
        chk("err_underflow", 64'(bus.err_underflow), 64'(merr));
        chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(mvalid));
        bus.rd_req_valid = rv; bus.rd_req_addr = ra;
        bus.wr_req_valid = wv; bus.wr_req_addr = wa;
        bus.mem_req_ready = mr;
        bus.wr_done_valid = dv; bus.wr_done_addr = da;
        if (dv) begin
            for (int i = 0; i < outstanding.size(); i++) begin
                if (outstanding[i] == da) begin
                    outstanding.delete(i);
                    break;
                end
            end
        end
        #1;
        slot = !mvalid || mr;
        re = rv && (mcnt[h(ra)] == 0);
        we = wv && (mcnt[h(wa)] < (1 << (BPB - 1))) && (mwr < MAXW);
        gr = 0; gw = 0;
        if (slot) begin
            if (re && we) begin
                if (mrr_wr) gr = 1; else gw = 1;
            end else begin
                gr = re; gw = we;
            end
        end
        chk("rd_req_ready", 64'(bus.rd_req_ready), 64'(gr));
        chk("wr_req_ready", 64'(bus.wr_req_ready), 64'(gw));
        if (gr) sb.push_back({1'b0, ra});
        if (gw) sb.push_back({1'b1, wa});
        p_gr = gr; p_gw = gw; p_wa = wa; p_dv = dv; p_da = da; p_mr = mr;
    endtask

    task automatic idle(input bit mr);
        step(0, '0, 0, '0, mr, 0, '0);
    endtask

    // Monitor: the held request must always match the oldest predicted one.
    always @(negedge clk) begin
        if (resetb && bus.mem_req_valid) begin
            if (sb.size() == 0) begin
                chk("mem_req_unexpected", {31'd0, bus.mem_req_is_wr, bus.mem_req_addr}, 64'h1_0000_0000_0000);
            end else begin
                chk("mem_req", {31'd0, bus.mem_req_is_wr, bus.mem_req_addr}, {31'd0, sb[0]});
                if (bus.mem_req_ready) void'(sb.pop_front());
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h12;
            1:       return 32'($urandom_range(0, 255));
            2:       return 32'($urandom);
            default: return 32'h30;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, wa, da;
        bit rv, wv, dv;
        int k;
        bus.rd_req_valid = 0; bus.rd_req_addr = '0;
        bus.wr_req_valid = 0; bus.wr_req_addr = '0;
        bus.mem_req_ready = 0;
        bus.wr_done_valid = 0; bus.wr_done_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("reset_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        chk("reset_wr_out_cnt", 64'(bus.wr_out_cnt), 64'd0);
        @(negedge clk) resetb = 1'b1;

        // Round-robin from reset: read wins the first tie
        for (int i = 0; i < 6; i++) step(1, 32'h01, 1, 32'h02, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 1, 1, 32'h02);

        // RAW stall on bucket 3; read of bucket 4 is unaffected
        step(0, '0, 1, 32'h12, 1, 0, '0);
        step(1, 32'h12, 0, '0, 1, 0, '0);
        step(1, 32'h30, 0, '0, 1, 0, '0);
        step(1, 32'h04, 0, '0, 1, 0, '0);
        step(1, 32'h12, 0, '0, 1, 1, 32'h12);
        step(1, 32'h12, 0, '0, 1, 0, '0);

        // Bucket full: eight writes to 0x12, ninth blocked until a completion lands
        for (int i = 0; i < 9; i++) step(0, '0, 1, 32'h12, 1, 0, '0);
        step(0, '0, 1, 32'h12, 1, 1, 32'h12);
        step(0, '0, 1, 32'h12, 1, 0, '0);

        // Backpressure: request held, no accepts, then resume
        for (int i = 0; i < 6; i++) step(1, 32'h04, 1, 32'h05, 0, 0, '0);
        step(1, 32'h04, 1, 32'h05, 1, 0, '0);
        step(1, 32'h04, 1, 32'h05, 1, 0, '0);

        // Drain everything in flight
        while (outstanding.size() > 0) step(0, '0, 0, '0, 1, 1, outstanding[0]);
        idle(1);

        // Randomised traffic
        for (int n = 0; n < 2500; n++) begin
            rv = ($urandom_range(0, 3) != 0); ra = rnd_addr();
            wv = ($urandom_range(0, 2) != 0); wa = rnd_addr();
            dv = 0; da = rnd_addr();
            if (outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, outstanding.size() - 1);
                da = outstanding[k];
                dv = 1;
            end
            step(rv, ra, wv, wa, ($urandom_range(0, 9) < 7), dv, da);
        end

        // Asynchronous reset in the middle of traffic
        step(1, 32'h04, 1, 32'h12, 0, 0, '0);
        resetb = 1'b0;
        #1;
        chk("midrst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("midrst_mem_req_is_wr", 64'(bus.mem_req_is_wr), 64'd0);
        chk("midrst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        chk("midrst_wr_out_cnt", 64'(bus.wr_out_cnt), 64'd0);
        chk("midrst_err_underflow", 64'(bus.err_underflow), 64'd0);
        chk("midrst_rd_req_ready", 64'(bus.rd_req_ready), 64'd0);
        chk("midrst_wr_req_ready", 64'(bus.wr_req_ready), 64'd0);
        model_reset();
        bus.rd_req_valid = 0; bus.wr_req_valid = 0; bus.wr_done_valid = 0; bus.mem_req_ready = 0;
        @(negedge clk);
        @(negedge clk) resetb = 1'b1;
        idle(1);
        idle(1);

        // Underflow: completion with nothing in flight sets the sticky flag
        step(0, '0, 0, '0, 1, 1, 32'h55);
        for (int i = 0; i < 4; i++) idle(1);
        step(1, 32'h55, 0, '0, 1, 0, '0);
        idle(1);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
